// File: rtl/ysyx_22050019_mem_arb.sv
// Two-master memory arbiter: load/store over fetch with starvation bound.
// One outstanding transaction; every grant ends in a response or timeout.
module ysyx_22050019_mem_arb #(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int TIMEOUT      = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rsp_data,
    input  logic              ls_req_valid,
    output logic              ls_req_ready,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic              ls_we,
    input  logic [DATA_W-1:0] ls_wdata,
    input  logic [7:0]        ls_wmask,
    output logic              ls_rsp_valid,
    output logic [DATA_W-1:0] ls_rsp_data,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [7:0]        mem_wmask,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic              bus_err
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_IF = 2'd1,
        WAIT_LS = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [SC_W-1:0]  starve_cnt;
    logic             we_q;

    logic idle;
    logic starved;
    logic gnt_ls;
    logic gnt_if;
    logic fire;
    logic done;

    // Gating with rst_n keeps the combinational request path quiet in reset.
    assign idle    = rst_n && (state == IDLE);
    assign starved = if_req_valid && (starve_cnt == SC_W'(STARVE_LIMIT));
    assign gnt_ls  = idle && ls_req_valid && !starved;
    assign gnt_if  = idle && if_req_valid && !gnt_ls;

    assign mem_req_valid = gnt_ls || gnt_if;
    assign fire          = mem_req_valid && mem_req_ready;
    assign if_req_ready  = gnt_if && mem_req_ready;
    assign ls_req_ready  = gnt_ls && mem_req_ready;

    assign done = mem_rsp_valid || (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        mem_wmask = '0;
        unique case (1'b1)
            gnt_ls: begin
                mem_addr  = ls_addr;
                mem_we    = ls_we;
                mem_wdata = ls_wdata;
                mem_wmask = ls_wmask;
            end
            gnt_if: begin
                mem_addr = if_addr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            starve_cnt   <= '0;
            we_q         <= 1'b0;
            if_rsp_valid <= 1'b0;
            if_rsp_data  <= '0;
            ls_rsp_valid <= 1'b0;
            ls_rsp_data  <= '0;
            bus_err      <= 1'b0;
        end else begin
            if_rsp_valid <= 1'b0;
            if_rsp_data  <= '0;
            ls_rsp_valid <= 1'b0;
            ls_rsp_data  <= '0;
            bus_err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (fire) begin
                        state    <= gnt_ls ? WAIT_LS : WAIT_IF;
                        wait_cnt <= '0;
                        we_q     <= gnt_ls && ls_we;
                        if (gnt_ls && if_req_valid) begin
                            if (starve_cnt != SC_W'(STARVE_LIMIT))
                                starve_cnt <= starve_cnt + SC_W'(1);
                        end else begin
                            starve_cnt <= '0;
                        end
                    end
                end
                WAIT_IF, WAIT_LS: begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                    // A response on the terminal count still completes normally.
                    if (done) begin
                        state   <= IDLE;
                        bus_err <= !mem_rsp_valid;
                        if (state == WAIT_IF) begin
                            if_rsp_valid <= 1'b1;
                            if_rsp_data  <= mem_rsp_valid ? mem_rsp_data : '0;
                        end else begin
                            ls_rsp_valid <= 1'b1;
                            ls_rsp_data  <= (mem_rsp_valid && !we_q) ?
                                            mem_rsp_data : '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22050019_mem_arb.sv
// Directed bench for ysyx_22050019_mem_arb: grant vectors plus
// fetch/load/store, starvation, timeout and reset sequences.
module tb_ysyx_22050019_mem_arb;

    localparam logic [63:0] IA = 64'h8000_0000;
    localparam logic [63:0] LA = 64'h8000_1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req_valid = 1'b0;
    logic        if_req_ready;
    logic [63:0] if_addr = '0;
    logic        if_rsp_valid;
    logic [63:0] if_rsp_data;
    logic        ls_req_valid = 1'b0;
    logic        ls_req_ready;
    logic [63:0] ls_addr = '0;
    logic        ls_we = 1'b0;
    logic [63:0] ls_wdata = '0;
    logic [7:0]  ls_wmask = '0;
    logic        ls_rsp_valid;
    logic [63:0] ls_rsp_data;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [63:0] mem_addr;
    logic        mem_we;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_rsp_valid;
    logic [63:0] mem_rsp_data;
    logic        bus_err;

    logic        mem_auto = 1'b0;
    logic        auto_rsp = 1'b0;
    logic        force_rsp = 1'b0;
    logic        hs_q = 1'b0;
    logic [63:0] mem_data_val = '0;

    int checks = 0;
    int failures = 0;
    int if_pulses = 0;
    int ls_pulses = 0;
    int err_pulses = 0;
    bit both_seen = 1'b0;

    ysyx_22050019_mem_arb #(
        .ADDR_W(64), .DATA_W(64), .TIMEOUT(64), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready),
        .if_addr(if_addr), .if_rsp_valid(if_rsp_valid),
        .if_rsp_data(if_rsp_data),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready),
        .ls_addr(ls_addr), .ls_we(ls_we), .ls_wdata(ls_wdata),
        .ls_wmask(ls_wmask), .ls_rsp_valid(ls_rsp_valid),
        .ls_rsp_data(ls_rsp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    assign mem_rsp_valid = auto_rsp | force_rsp;
    assign mem_rsp_data  = mem_rsp_valid ? mem_data_val : '0;

    // One-cycle memory: answers in the cycle after an accepted request.
    always begin
        @(negedge clk);
        #4;
        hs_q = mem_auto && mem_req_valid && mem_req_ready;
        @(posedge clk);
        #1;
        auto_rsp = hs_q;
    end

    always @(negedge clk) begin
        if (if_rsp_valid) if_pulses++;
        if (ls_rsp_valid) ls_pulses++;
        if (bus_err) err_pulses++;
        if (if_rsp_valid && ls_rsp_valid) both_seen = 1'b1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic req_if(input logic [63:0] a);
        bit got;
        got = 1'b0;
        if_addr = a;
        if_req_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (if_req_ready) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        chk("if_grant", 64'(got), 64'd1);
        if (got) tick();
        if_req_valid = 1'b0;
    endtask

    task automatic req_ls(input logic [63:0] a, input logic we);
        bit got;
        got = 1'b0;
        ls_addr = a;
        ls_we = we;
        ls_req_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (ls_req_ready) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        chk("ls_grant", 64'(got), 64'd1);
        if (got) tick();
        ls_req_valid = 1'b0;
        ls_we = 1'b0;
    endtask

    typedef struct {
        logic        if_v;
        logic        ls_v;
        logic        we;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic        rdy;
        logic        e_valid;
        logic [63:0] e_addr;
        logic        e_we;
        logic [63:0] e_wdata;
        logic [7:0]  e_wmask;
        logic        e_if_rdy;
        logic        e_ls_rdy;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int p0, p1, e0, found, n;
        logic [5:0] seq;

        vecs[0] = '{0, 0, 0, 64'h0, 8'h00, 1, 0, 64'h0, 0, 64'h0, 8'h00, 0, 0};
        vecs[1] = '{1, 0, 0, 64'h0, 8'h00, 1, 1, IA, 0, 64'h0, 8'h00, 1, 0};
        vecs[2] = '{1, 0, 0, 64'h0, 8'h00, 0, 1, IA, 0, 64'h0, 8'h00, 0, 0};
        vecs[3] = '{0, 1, 0, 64'h0, 8'h00, 1, 1, LA, 0, 64'h0, 8'h00, 0, 1};
        vecs[4] = '{0, 1, 1, 64'hDEADBEEF, 8'h0F, 1,
                    1, LA, 1, 64'hDEADBEEF, 8'h0F, 0, 1};
        vecs[5] = '{1, 1, 1, 64'hDEADBEEF, 8'h0F, 1,
                    1, LA, 1, 64'hDEADBEEF, 8'h0F, 0, 1};
        vecs[6] = '{1, 1, 0, 64'h0, 8'h00, 0, 1, LA, 0, 64'h0, 8'h00, 0, 0};
        vecs[7] = '{0, 0, 1, 64'hDEADBEEF, 8'h0F, 1,
                    0, 64'h0, 0, 64'h0, 8'h00, 0, 0};

        // Reset: every output low even with live requests.
        if_req_valid = 1'b1;
        ls_req_valid = 1'b1;
        mem_req_ready = 1'b1;
        if_addr = IA;
        ls_addr = LA;
        tick();
        tick();
        chk("rst mem_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst if_req_ready", 64'(if_req_ready), 64'd0);
        chk("rst ls_req_ready", 64'(ls_req_ready), 64'd0);
        chk("rst mem_addr", mem_addr, 64'd0);
        chk("rst rsp/err", 64'({if_rsp_valid, ls_rsp_valid, bus_err}), 64'd0);
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Combinational grant vectors, removed before the clock edge.
        for (int i = 0; i < 8; i++) begin
            tick();
            if_addr = IA;
            ls_addr = LA;
            if_req_valid = vecs[i].if_v;
            ls_req_valid = vecs[i].ls_v;
            ls_we = vecs[i].we;
            ls_wdata = vecs[i].wdata;
            ls_wmask = vecs[i].wmask;
            mem_req_ready = vecs[i].rdy;
            #1;
            chk($sformatf("vec%0d mem_req_valid", i),
                64'(mem_req_valid), 64'(vecs[i].e_valid));
            chk($sformatf("vec%0d mem_addr", i), mem_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d mem_we", i), 64'(mem_we), 64'(vecs[i].e_we));
            chk($sformatf("vec%0d mem_wdata", i), mem_wdata, vecs[i].e_wdata);
            chk($sformatf("vec%0d mem_wmask", i),
                64'(mem_wmask), 64'(vecs[i].e_wmask));
            chk($sformatf("vec%0d if_req_ready", i),
                64'(if_req_ready), 64'(vecs[i].e_if_rdy));
            chk($sformatf("vec%0d ls_req_ready", i),
                64'(ls_req_ready), 64'(vecs[i].e_ls_rdy));
            #1;
            if_req_valid = 1'b0;
            ls_req_valid = 1'b0;
            ls_we = 1'b0;
            ls_wdata = '0;
            ls_wmask = '0;
        end
        mem_req_ready = 1'b1;
        mem_auto = 1'b1;
        tick();

        // Single fetch.
        p0 = ls_pulses;
        mem_data_val = 64'h0000_0413;
        req_if(IA);
        chk("fetch wait rsp", 64'(if_rsp_valid), 64'd0);
        tick();
        chk("fetch rsp_valid", 64'(if_rsp_valid), 64'd1);
        chk("fetch rsp_data", if_rsp_data, 64'h413);
        tick();
        chk("fetch pulse width", 64'(if_rsp_valid), 64'd0);
        chk("fetch no ls", 64'(ls_pulses - p0), 64'd0);

        // IF and LS load together: LS first, then IF.
        ls_addr = LA;
        if_addr = IA + 64'h4;
        mem_data_val = 64'h1111_2222_3333_4444;
        ls_req_valid = 1'b1;
        if_req_valid = 1'b1;
        #1;
        chk("both ls_ready", 64'(ls_req_ready), 64'd1);
        chk("both if_ready", 64'(if_req_ready), 64'd0);
        tick();
        ls_req_valid = 1'b0;
        tick();
        chk("both ls rsp_valid", 64'(ls_rsp_valid), 64'd1);
        chk("both ls rsp_data", ls_rsp_data, 64'h1111_2222_3333_4444);
        chk("both if_ready next", 64'(if_req_ready), 64'd1);
        chk("both if addr", mem_addr, IA + 64'h4);
        mem_data_val = 64'h0000_0000_0000_2222;
        tick();
        if_req_valid = 1'b0;
        tick();
        chk("both if rsp_valid", 64'(if_rsp_valid), 64'd1);
        chk("both if rsp_data", if_rsp_data, 64'h2222);
        tick();

        // Store: payload forwarded, response data zero.
        mem_data_val = 64'h5555;
        ls_addr = LA + 64'h8;
        ls_we = 1'b1;
        ls_wdata = 64'hDEADBEEF;
        ls_wmask = 8'h0F;
        ls_req_valid = 1'b1;
        #1;
        chk("store mem_we", 64'(mem_we), 64'd1);
        chk("store mem_wmask", 64'(mem_wmask), 64'h0F);
        chk("store mem_wdata", mem_wdata, 64'hDEADBEEF);
        chk("store ls_ready", 64'(ls_req_ready), 64'd1);
        tick();
        ls_req_valid = 1'b0;
        ls_we = 1'b0;
        tick();
        chk("store rsp_valid", 64'(ls_rsp_valid), 64'd1);
        chk("store rsp_data", ls_rsp_data, 64'd0);
        ls_wdata = '0;
        ls_wmask = '0;
        tick();

        // Starvation: four LS grants, one forced IF grant, then LS again.
        seq = '0;
        n = 0;
        ls_addr = LA;
        if_addr = IA;
        ls_req_valid = 1'b1;
        if_req_valid = 1'b1;
        for (int i = 0; i < 60 && n < 6; i++) begin
            #1;
            if (ls_req_ready) begin
                seq = {seq[4:0], 1'b1};
                n++;
            end else if (if_req_ready) begin
                seq = {seq[4:0], 1'b0};
                n++;
            end
            tick();
        end
        ls_req_valid = 1'b0;
        if_req_valid = 1'b0;
        chk("starve grants", 64'(n), 64'd6);
        chk("starve order", 64'(seq), 64'(6'b111101));
        tick();
        tick();
        tick();

        // Timeout with no memory response.
        mem_auto = 1'b0;
        p0 = ls_pulses;
        p1 = if_pulses;
        e0 = err_pulses;
        req_ls(LA, 1'b0);
        found = 0;
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (bus_err) begin
                found = k;
                break;
            end
        end
        chk("timeout latency", 64'(found), 64'd64);
        chk("timeout ls_rsp_valid", 64'(ls_rsp_valid), 64'd1);
        chk("timeout ls_rsp_data", ls_rsp_data, 64'd0);
        chk("timeout ls pulses", 64'(ls_pulses - p0), 64'd1);
        tick();
        chk("timeout err width", 64'(bus_err), 64'd0);
        mem_data_val = 64'h77;
        force_rsp = 1'b1;
        tick();
        force_rsp = 1'b0;
        tick();
        tick();
        chk("late rsp ls ignored", 64'(ls_pulses - p0), 64'd1);
        chk("late rsp if ignored", 64'(if_pulses - p1), 64'd0);
        chk("err pulses", 64'(err_pulses - e0), 64'd1);

        // Response on the terminal count wins over the timeout.
        p0 = ls_pulses;
        e0 = err_pulses;
        req_ls(LA + 64'h10, 1'b0);
        for (int k = 1; k <= 63; k++) tick();
        chk("edge no early rsp", 64'(ls_pulses - p0), 64'd0);
        mem_data_val = 64'hABCD;
        force_rsp = 1'b1;
        tick();
        force_rsp = 1'b0;
        chk("edge rsp_valid", 64'(ls_rsp_valid), 64'd1);
        chk("edge rsp_data", ls_rsp_data, 64'hABCD);
        chk("edge no bus_err", 64'(bus_err), 64'd0);
        tick();
        chk("edge err count", 64'(err_pulses - e0), 64'd0);

        // Reset while waiting on a fetch.
        req_if(IA + 64'h100);
        tick();
        if_req_valid = 1'b1;
        ls_req_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("midrst mem_req_valid", 64'(mem_req_valid), 64'd0);
        chk("midrst readies", 64'({if_req_ready, ls_req_ready}), 64'd0);
        chk("midrst mem_addr", mem_addr, 64'd0);
        chk("midrst rsp/err", 64'({if_rsp_valid, ls_rsp_valid, bus_err}),
            64'd0);
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        p1 = if_pulses;
        force_rsp = 1'b1;
        tick();
        force_rsp = 1'b0;
        tick();
        tick();
        chk("midrst no if rsp", 64'(if_pulses - p1), 64'd0);
        mem_auto = 1'b1;
        mem_data_val = 64'h13;
        req_if(IA);
        tick();
        chk("post rst fetch valid", 64'(if_rsp_valid), 64'd1);
        chk("post rst fetch data", if_rsp_data, 64'h13);
        tick();

        chk("rsp exclusive", 64'(both_seen), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_22050019_mem_arb.md
Name: ysyx_22050019_mem_arb

Overview:
Two-master, one-slave memory arbiter that lets the instruction-fetch path and the load/store path share a single memory port, so the core can move from separate fetch/data memories to one unified memory.
Load/store has fixed priority over fetch, and a starvation counter bounds how long fetch can be held off.
Only one transaction is outstanding at a time; every transaction ends in a response, or in a timeout error.
Sits between IFU/EXU and the memory model.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, data width
TIMEOUT, 64, max cycles in WAIT before abort (>=2)
STARVE_LIMIT, 4, consecutive LS grants while IF waits before IF is forced (>=1)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
if_req_valid  in  1  fetch request; held stable until if_req_ready
if_req_ready  out  1  fetch request accepted this cycle
if_addr  in  ADDR_W  fetch address
if_rsp_valid  out  1  one-cycle fetch response pulse
if_rsp_data  out  DATA_W  fetch data (0 on error)
ls_req_valid  in  1  load/store request; held stable until ls_req_ready
ls_req_ready  out  1  load/store request accepted
ls_addr  in  ADDR_W  data address
ls_we  in  1  1=store, 0=load
ls_wdata  in  DATA_W  store data
ls_wmask  in  8  store byte mask
ls_rsp_valid  out  1  one-cycle load/store response pulse
ls_rsp_data  out  DATA_W  load data (0 for stores and on error)
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_addr  out  ADDR_W  muxed address
mem_we  out  1  muxed write enable (0 for fetch)
mem_wdata  out  DATA_W  muxed store data (0 for fetch)
mem_wmask  out  8  muxed mask (0 for fetch)
mem_rsp_valid  in  1  memory response/ack
mem_rsp_data  in  DATA_W  memory read data
bus_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- States: IDLE, WAIT_IF, WAIT_LS. Reset enters IDLE with wait_cnt=0, starve_cnt=0 and all registered outputs 0. While rst_n=0 every output is 0.
- IDLE grant rule:
  - LS is granted if ls_req_valid=1 and not (if_req_valid=1 and starve_cnt==STARVE_LIMIT).
  - Otherwise IF is granted if if_req_valid=1.
  - Otherwise no grant: mem_req_valid=0 and the mem_* payload is 0.
- Request path is combinational in IDLE: mem_req_valid = valid of the granted master; payload comes from the granted master; granted *_req_ready = mem_req_ready; ungranted ready = 0.
- Handshake fires when mem_req_valid & mem_req_ready. Next state is WAIT_IF or WAIT_LS, and wait_cnt is cleared.
- Starvation counter (updated only on a fired grant):
  - LS grant with if_req_valid=1: starve_cnt+1, saturating at STARVE_LIMIT.
  - IF grant, or LS grant with if_req_valid=0: starve_cnt=0.
- WAIT_x: mem_req_valid=0, both req_ready=0, wait_cnt increments each cycle.
- Normal completion: mem_rsp_valid=1 in WAIT_x → next cycle the owner's rsp_valid=1 for exactly one cycle. rsp_data = registered mem_rsp_data; it is 0 if the owner is LS and the access was a store (ls_we is latched at grant). State returns to IDLE.
- A new grant may fire in the same cycle the rsp_valid pulse is high (back-to-back, 3-cycle minimum per transaction with mem_req_ready=1 and a 1-cycle memory).
- Timeout: in WAIT_x with wait_cnt==TIMEOUT-1 and mem_rsp_valid=0 → next cycle owner rsp_valid=1, rsp_data=0, bus_err=1 (one cycle); state returns to IDLE.
- A response arriving in the same cycle as the terminal count wins: normal completion, no error.
- mem_rsp_valid in IDLE (stale or late) is ignored; no rsp pulse is produced.
- if_rsp_valid and ls_rsp_valid are never high in the same cycle.
- Reset asserted mid-transaction: the transaction is dropped, no response is generated, state goes to IDLE immediately (async).

Test Plan:
- Single fetch, if_addr=0x80000000, mem ready=1, rsp 1 cycle later with 0x00000413 → if_rsp_valid pulse at cycle 3 with data 0x413; no ls activity.
- Simultaneous IF+LS load (ls_addr=0x80001000) → LS granted first, ls_rsp_data=mem data; IF granted on the next IDLE.
- Store ls_wdata=0xDEADBEEF, ls_wmask=0x0F → mem_we=1, mem_wmask=0x0F; ls_rsp_valid pulse with ls_rsp_data=0.
- LS held valid continuously, IF valid, STARVE_LIMIT=4 → 4 LS grants, then 1 IF grant, then starve_cnt=0 and LS resumes.
- Memory never responds, TIMEOUT=64 → bus_err and ls_rsp_valid pulse 64 cycles after grant, data 0; a late mem_rsp_valid afterwards produces no pulse.
- rst_n dropped in WAIT_IF → all outputs 0 immediately; after release, no if_rsp_valid and a fresh request completes normally.
